// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: per-stage hold/flush control for load-use, multi-cycle ops, mem wait and jump redirect.
// Define HOLD_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hold_ctrl #(
   parameter int                STAGES     = 4,
   parameter int                ADDR_W     = 32,
   parameter int                LOAD_CYC   = 1,
   parameter logic [STAGES-1:0] FLUSH_MASK = 4'b0110,
   parameter int                CNT_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_jump_flag,
   input  logic [ADDR_W-1:0] i_jump_addr,
   input  logic              i_load_hazard,
   input  logic              i_busy_start,
   input  logic              i_busy_done,
   input  logic              i_mem_wait,
   output logic [STAGES-1:0] o_hold,
   output logic [STAGES-1:0] o_flush,
   output logic              o_jump_flag,
   output logic [ADDR_W-1:0] o_jump_addr,
   output logic [1:0]        o_state,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);
   typedef enum logic [1:0] {S_RUN = 2'd0, S_LOAD = 2'd1, S_BUSY = 2'd2} state_t;
   // stage bits above 3 mirror bit3, so busy flushes everything from ex onward
   localparam logic [STAGES-1:0] BUSY_HOLD  = {{(STAGES-3){1'b0}}, 3'b111};
   localparam logic [STAGES-1:0] BUSY_FLUSH = {{(STAGES-3){1'b1}}, 3'b000};
   localparam logic [STAGES-1:0] LOAD_HOLD  = {{(STAGES-2){1'b0}}, 2'b11};
   localparam logic [STAGES-1:0] LOAD_FLUSH = {{(STAGES-3){1'b0}}, 3'b100};
   localparam logic [3:0]        LOAD_INIT  = (LOAD_CYC > 1) ? 4'(LOAD_CYC - 2) : 4'd0;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic [STAGES-1:0] w_hold;
   logic [STAGES-1:0] w_flush;
   logic              w_jump;

   always_comb begin
      w_hold      = '0;
      w_flush     = '0;
      w_jump      = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!i_reset) begin
         w_state_nxt = S_RUN;
         w_cnt_nxt   = '0;
      end else if (i_mem_wait) begin
         w_hold = '1;
      end else if (i_jump_flag && r_state != S_BUSY) begin
         w_jump      = 1'b1;
         w_flush     = FLUSH_MASK;
         w_state_nxt = S_RUN;
         w_cnt_nxt   = '0;
      end else if (r_state == S_BUSY) begin
         w_hold      = i_busy_done ? '0 : BUSY_HOLD;
         w_flush     = i_busy_done ? '0 : BUSY_FLUSH;
         w_state_nxt = i_busy_done ? S_RUN : S_BUSY;
      end else if (r_state == S_LOAD) begin
         w_hold      = LOAD_HOLD;
         w_flush     = LOAD_FLUSH;
         w_state_nxt = (r_cnt == 4'd0) ? S_RUN : S_LOAD;
         w_cnt_nxt   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
      end else if (i_busy_start) begin
         w_hold      = BUSY_HOLD;
         w_flush     = BUSY_FLUSH;
         w_state_nxt = S_BUSY;
      end else if (i_load_hazard) begin
         w_hold      = LOAD_HOLD;
         w_flush     = LOAD_FLUSH;
         w_state_nxt = (LOAD_CYC > 1) ? S_LOAD : S_RUN;
         w_cnt_nxt   = LOAD_INIT;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign o_hold      = w_hold;
   assign o_flush     = w_flush;
   assign o_jump_flag = w_jump;
   assign o_jump_addr = w_jump ? i_jump_addr : '0;
   assign o_state     = r_state;

`ifdef HOLD_CTRL_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (|w_hold && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_jump && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_flush_cnt = r_flush_cnt;
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of controlled stages (bit0 = pc, bit k = k-th pipeline buffer; min 4).
REQ-002 SHALL have parameter ADDR_W, default 32, jump address width.
REQ-003 SHALL have parameter LOAD_CYC, default 1, total load-use stall cycles (legal 1..15).
REQ-004 SHALL have parameter FLUSH_MASK, default 4'b0110, stages flushed on jump (STAGES bits).
REQ-005 SHALL have parameter CNT_W, default 32, perf counter width.
REQ-006 SHALL have ports: i_clk  in  1  clock, rising edge; i_reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports: i_jump_flag in 1 ex redirect request; i_jump_addr in ADDR_W target; i_load_hazard in 1 id load-use hazard; i_busy_start in 1 ex multi-cycle op start; i_busy_done in 1 multi-cycle op result ready; i_mem_wait in 1 mem stage wait (level).
REQ-008 SHALL have ports: o_hold out STAGES hold per stage; o_flush out STAGES bubble per stage; o_jump_flag out 1; o_jump_addr out ADDR_W; o_state out 2; o_stall_cnt out CNT_W; o_flush_cnt out CNT_W.

Function
REQ-009 SHALL implement FSM states S_RUN=0, S_LOAD=1, S_BUSY=2, reported on o_state.
REQ-010 SHALL drive o_hold/o_flush/o_jump_* combinationally from state and inputs (zero-cycle latency); state/counters update on i_clk.
REQ-011 SHALL, priority 1, when i_mem_wait=1: o_hold all ones, o_flush 0, o_jump_flag 0; FSM state and load counter frozen; jump ignored (ex re-presents it).
REQ-012 SHALL, priority 2, when i_jump_flag=1 in S_RUN or S_LOAD: o_jump_flag=1, o_jump_addr=i_jump_addr, o_flush=FLUSH_MASK, o_hold=0; next state S_RUN (pending load stall cancelled).
REQ-013 SHALL, priority 3, in S_RUN on i_busy_start=1: o_hold bits[2:0]=1, o_flush bit3=1; next state S_BUSY.
REQ-014 SHALL in S_BUSY: same hold/flush as REQ-013 each cycle i_busy_done=0; on i_busy_done=1 release hold that cycle and return S_RUN; i_jump_flag and i_busy_start ignored in S_BUSY.
REQ-015 SHALL, priority 4, in S_RUN on i_load_hazard=1: o_hold bits[1:0]=1, o_flush bit2=1; if LOAD_CYC>1 enter S_LOAD with counter=LOAD_CYC-2.
REQ-016 SHALL in S_LOAD assert REQ-015 hold/flush irrespective of i_load_hazard; counter decrements each cycle; return S_RUN in the cycle after counter reaches 0 (total stall = LOAD_CYC cycles).
REQ-017 SHALL, when i_busy_start and i_load_hazard coincide, serve busy only; load hazard is re-presented by held id stage.
REQ-018 SHALL drive o_jump_addr=0 whenever o_jump_flag=0; bits of o_hold/o_flush above bit3 follow bit3 except under mem wait or FLUSH_MASK.
REQ-019 SHALL in S_RUN with no request output all zero.

Reset
REQ-020 SHALL, on rising i_clk with i_reset=0, set state S_RUN, load counter 0, perf counters 0.
REQ-021 SHALL force all o_hold, o_flush, o_jump_flag, o_jump_addr to 0 while i_reset=0, regardless of inputs; reset mid-stall abandons the stall.

Configuration
REQ-022 SHALL, with HOLD_CTRL_PERF_EN defined, increment o_stall_cnt each cycle any o_hold bit is 1 and o_flush_cnt each cycle o_jump_flag is 1, both saturating at 2^CNT_W-1.
REQ-023 SHALL, without HOLD_CTRL_PERF_EN, tie o_stall_cnt and o_flush_cnt to 0 with no counter flops.

Verification
REQ-024 SHALL cover: LOAD_CYC=3, i_load_hazard pulse 1 cycle -> o_hold=4'b0011, o_flush=4'b0100 for exactly 3 cycles, o_state 0->1->1->0.
REQ-025 SHALL cover: i_busy_start pulse, i_busy_done high 5 cycles later -> o_hold=4'b0111 for 5 cycles, released in done cycle, o_state back to 0.
REQ-026 SHALL cover: i_jump_flag=1, addr 0x0000_0100, during S_LOAD -> o_jump_addr=0x100, o_flush=4'b0110, o_hold=0, next o_state=0.
REQ-027 SHALL cover: i_mem_wait=1 for 2 cycles during S_LOAD (LOAD_CYC=3) with jump asserted -> o_hold=4'b1111, no jump; stall resumes remaining cycles after wait.
REQ-028 SHALL cover: i_reset=0 during S_BUSY -> outputs 0 immediately, o_state=0 next cycle, perf counters 0.
REQ-029 SHALL cover: HOLD_CTRL_PERF_EN, CNT_W=4, 20 stall cycles -> o_stall_cnt saturates at 15.
